// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard/stall requests and multi-cycle/flush commands in,
// per-stage hold, flush redirect and multi-cycle status out.
interface pipeline_ctrl_if;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned STAGES_W = 6;

  logic                stallreq_id;
  logic                stallreq_ex;
  logic                mc_start;
  logic [CNT_W-1:0]    mc_cycles;
  logic                flush_req;
  logic [ADDR_W-1:0]   flush_target;
  logic [STAGES_W-1:0] stall;
  logic                flush;
  logic [ADDR_W-1:0]   new_pc;
  logic                mc_busy;
  logic                mc_done;

  modport master (
    output stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_target,
    input  stall, flush, new_pc, mc_busy, mc_done
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_target,
    output stall, flush, new_pc, mc_busy, mc_done
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: resolves per-stage stalls, sequences multi-cycle
// execute operations and issues registered flush/redirect pulses.
module pipeline_ctrl (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned STAGES_W = 6;

  localparam logic [STAGES_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STAGES_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STAGES_W-1:0] STALL_ID   = 6'b000111;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_flush;
  logic                w_flush_nxt;
  logic [ADDR_W-1:0]   r_new_pc;
  logic [ADDR_W-1:0]   w_new_pc_nxt;
  logic                r_mc_busy;
  logic                w_mc_busy_nxt;
  logic                r_mc_done;
  logic                w_mc_done_nxt;
  logic [STAGES_W-1:0] w_stall;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_flush   <= 1'b0;
      r_new_pc  <= '0;
      r_mc_busy <= 1'b0;
      r_mc_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_flush   <= w_flush_nxt;
      r_new_pc  <= w_new_pc_nxt;
      r_mc_busy <= w_mc_busy_nxt;
      r_mc_done <= w_mc_done_nxt;
    end
  end

  // Next state; a flush request overrides mc_start and aborts a running operation
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_flush_nxt  = bus.flush_req;
    w_new_pc_nxt = bus.flush_req ? bus.flush_target : r_new_pc;

    if (bus.flush_req) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mc_start) begin
            w_state_nxt = MC_RUN;
            w_cnt_nxt   = (bus.mc_cycles == '0) ? CNT_W'(1) : bus.mc_cycles;
          end
        end
        MC_RUN: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // done is registered so it is high exactly during the cnt==1 cycle
    w_mc_busy_nxt = (w_state_nxt == MC_RUN);
    w_mc_done_nxt = (w_state_nxt == MC_RUN) && (w_cnt_nxt == CNT_W'(1));
  end

  // Stall priority: reset/flush, then multi-cycle or EX request, then ID request
  always_comb begin
    w_stall = STALL_NONE;
    if (!rst || r_flush) begin
      w_stall = STALL_NONE;
    end else if ((r_state == MC_RUN) || bus.mc_start || bus.stallreq_ex) begin
      w_stall = STALL_EX;
    end else if (bus.stallreq_id) begin
      w_stall = STALL_ID;
    end
  end

  assign bus.stall   = w_stall;
  assign bus.flush   = r_flush;
  assign bus.new_pc  = r_new_pc;
  assign bus.mc_busy = r_mc_busy;
  assign bus.mc_done = r_mc_done;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-low (rst=0 resets; polarity and synchronicity are fixed).
REQ-002 Port `clk`, input, 1 bit: rising-edge clock.
REQ-003 Port `rst`, input, 1 bit: async active-low reset.
REQ-004 Port `stallreq_id`, input, 1 bit: decode stage requests a stall (load-use hazard).
REQ-005 Port `stallreq_ex`, input, 1 bit: execute stage requests a single-cycle stall.
REQ-006 Port `mc_start`, input, 1 bit: execute stage starts a multi-cycle operation (div/madd).
REQ-007 Port `mc_cycles`, input, 6 bits: length of the multi-cycle operation, sampled with `mc_start`.
REQ-008 Port `flush_req`, input, 1 bit: exception or eret redirect request.
REQ-009 Port `flush_target`, input, 32 bits: redirect address, sampled with `flush_req`.
REQ-010 Port `stall`, output, 6 bits: per-stage hold; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
REQ-011 Port `flush`, output, 1 bit: registered one-cycle pipeline-flush pulse.
REQ-012 Port `new_pc`, output, 32 bits: redirect address for the PC register; valid while `flush`=1.
REQ-013 Port `mc_busy`, output, 1 bit: a multi-cycle operation is in progress.
REQ-014 Port `mc_done`, output, 1 bit: one-cycle pulse in the final cycle of a multi-cycle operation.

Function
REQ-015 The block SHALL implement states IDLE and MC_RUN, plus a 6-bit down-counter `cnt`.
REQ-016 In IDLE, `mc_start`=1 with `flush_req`=0 SHALL load `cnt` with `mc_cycles` (0 treated as 1) and move to MC_RUN at the next edge.
REQ-017 In MC_RUN, `cnt` SHALL decrement each cycle; in the cycle where `cnt`==1, `mc_done`=1, and the next state SHALL be IDLE with `cnt`=0.
REQ-018 `mc_start` SHALL be ignored while in MC_RUN.
REQ-019 `mc_busy` SHALL equal 1 exactly while in MC_RUN.
REQ-020 `stall` SHALL be combinational and resolved by priority:
- `flush`=1 -> 6'b000000.
- Else MC_RUN, `mc_start`=1, or `stallreq_ex`=1 -> 6'b001111.
- Else `stallreq_id`=1 -> 6'b000111.
- Else 6'b000000.
REQ-021 `flush_req`=1 at an edge SHALL set `flush`=1 and `new_pc`=`flush_target` for exactly the following cycle; `flush` SHALL return to 0 afterwards unless `flush_req` is still 1.
REQ-022 `new_pc` SHALL hold its last value when `flush`=0.
REQ-023 `flush_req`=1 SHALL take priority over `mc_start` and SHALL abort MC_RUN: next state IDLE, `cnt`=0, no `mc_done` pulse.
REQ-024 Back-to-back `flush_req` SHALL produce `flush`=1 on consecutive cycles, with `new_pc` updated each cycle.
REQ-025 A new `mc_start` SHALL be accepted in the cycle after `mc_done`, since the state is already IDLE.
REQ-026 Outputs SHALL contain no X when inputs are known.

Reset
REQ-027 While `rst`=0 (asynchronous), the block SHALL force state=IDLE, `cnt`=0, `flush`=0, `new_pc`=32'h0000_0000, `mc_busy`=0, and `mc_done`=0.
REQ-028 While `rst`=0, `stall` SHALL be 6'b000000 regardless of inputs.
REQ-029 Reset asserted mid-MC_RUN SHALL abort immediately, with no `mc_done` pulse.
REQ-030 The first `mc_start` or `flush_req` SHALL be honoured at the first rising edge after `rst` goes to 1.

Verification
REQ-031 Load-use: `stallreq_id`=1 for 1 cycle -> `stall`=6'b000111 that cycle, then 6'b000000.
REQ-032 Multi-cycle: `mc_start`=1 with `mc_cycles`=5 -> `stall`=6'b001111 for 6 cycles, `mc_busy`=1 for 5 cycles, `mc_done`=1 in the 5th busy cycle only.
REQ-033 Zero length: `mc_start`=1 with `mc_cycles`=0 -> 1 MC_RUN cycle with `mc_done`=1, then IDLE.
REQ-034 Abort: `flush_req`=1 with `flush_target`=32'h0000_0180 at the 3rd MC_RUN cycle -> next cycle `flush`=1, `new_pc`=32'h0000_0180, `stall`=0, `mc_busy`=0, no `mc_done`.
REQ-035 Priority: `stallreq_id`=1, `stallreq_ex`=1, and `flush`=1 simultaneously -> `stall`=6'b000000; the next cycle with only both requests -> `stall`=6'b001111.
REQ-036 Async reset: pull `rst` low between clock edges during MC_RUN -> `mc_busy`, `flush`, and `stall` go to 0 immediately, before the next edge.
